pcie_dma_mwr_split: RTL

Memory-write request splitter that sits directly upstream of the PCIe TX arbiter/transmit stage, on one of its MWr request channels. It accepts a DMA write command (start address, length in DWORDs) and issues it as a sequence of MWr TLP requests. Each TLP is bounded by the negotiated max payload size and never crosses a 4 KB address boundary. It also limits the number of TLPs that are granted but whose payload is not yet drained, and signals command completion once every TLP's payload has left the TX stage.

---
 rtl/pcie_dma_mwr_split.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pcie_dma_mwr_split.sv
// Splits a DMA write command into MWr TLP requests bounded by max payload size
// and 4 KB address boundaries, with a cap on granted-but-undrained TLPs.
module pcie_dma_mwr_split #(
    parameter int C_PCIE_ADDR_WIDTH = 48,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic                         pcie_user_clk,
    input  logic                         pcie_user_rst,
    input  logic [2:0]                   pcie_max_payload_size,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [C_PCIE_ADDR_WIDTH-3:0] cmd_addr,
    input  logic [17:0]                  cmd_len,
    output logic                         cmd_done,
    output logic                         busy,
    output logic                         tx_mwr_req,
    output logic [7:0]                   tx_mwr_tag,
    output logic [10:0]                  tx_mwr_len,
    output logic [C_PCIE_ADDR_WIDTH-3:0] tx_mwr_addr,
    input  logic                         tx_mwr_req_ack,
    input  logic                         tx_mwr_data_last,
    output logic                         err_underflow
);

    // state  | meaning
    // IDLE   | ready for a command
    // CALC   | size next TLP, wait for outstanding headroom
    // REQ    | request held until the TX stage acks
    // DRAIN  | all TLPs granted, waiting for payloads to leave
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_REQ, S_DRAIN} state_t;

    localparam logic [3:0] MAX_OUT = 4'(C_MAX_OUTSTANDING);

    state_t                       state;
    logic [C_PCIE_ADDR_WIDTH-3:0] cur_addr;
    logic [17:0]                  remaining;
    logic [7:0]                   mps_dw;
    logic [10:0]                  tlp_len;
    logic [7:0]                   tag;
    logic [3:0]                   outstanding;
    logic                         cmd_ready_q;
    logic                         cmd_done_q;
    logic                         busy_q;
    logic                         req_q;
    logic                         err_q;

    logic [7:0]                   mps_sel;
    logic [10:0]                  dw_to_4k;
    logic [10:0]                  cap_len;
    logic [10:0]                  calc_len;
    logic                         ack_fire;

    always_comb begin
        case (pcie_max_payload_size)
            3'd0:    mps_sel = 8'd32;
            3'd1:    mps_sel = 8'd64;
            default: mps_sel = 8'd128;
        endcase
    end

    // DW address bits [9:0] are byte address bits [11:2]: distance to the next 4 KB page
    assign dw_to_4k = 11'd1024 - {1'b0, cur_addr[9:0]};
    assign cap_len  = ({3'd0, mps_dw} < dw_to_4k) ? {3'd0, mps_dw} : dw_to_4k;
    assign calc_len = (remaining < {7'd0, cap_len}) ? remaining[10:0] : cap_len;
    assign ack_fire = req_q & tx_mwr_req_ack;

    always_ff @(posedge pcie_user_clk) begin
        if (pcie_user_rst) begin
            state       <= S_IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            mps_dw      <= '0;
            tlp_len     <= '0;
            tag         <= '0;
            outstanding <= '0;
            cmd_ready_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmd_done_q <= 1'b0;

            // A drain completion with nothing outstanding is a TX-side protocol error
            if (tx_mwr_data_last && outstanding == 4'd0)
                err_q <= 1'b1;
            if (ack_fire && !tx_mwr_data_last)
                outstanding <= outstanding + 4'd1;
            else if (!ack_fire && tx_mwr_data_last && outstanding != 4'd0)
                outstanding <= outstanding - 4'd1;

            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cur_addr    <= cmd_addr;
                        remaining   <= cmd_len;
                        mps_dw      <= mps_sel;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= (cmd_len == 18'd0) ? S_DRAIN : S_CALC;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_CALC: begin
                    tlp_len <= calc_len;
                    if (outstanding < MAX_OUT) begin
                        req_q <= 1'b1;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (tx_mwr_req_ack) begin
                        req_q     <= 1'b0;
                        cur_addr  <= cur_addr + {{(C_PCIE_ADDR_WIDTH-13){1'b0}}, tlp_len};
                        remaining <= remaining - {7'd0, tlp_len};
                        tag       <= tag + 8'd1;
                        state     <= (remaining == {7'd0, tlp_len}) ? S_DRAIN : S_CALC;
                    end
                end
                S_DRAIN: begin
                    if (outstanding == 4'd0) begin
                        cmd_done_q  <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign cmd_done      = cmd_done_q;
    assign busy          = busy_q;
    assign tx_mwr_req    = req_q;
    assign tx_mwr_tag    = tag;
    assign tx_mwr_len    = tlp_len;
    assign tx_mwr_addr   = cur_addr;
    assign err_underflow = err_q;

endmodule
